sao_apply_one_block: RTL and testbench
======================================

// Module: sao_apply_one_block
// PURPOSE
//  Decoder/reconstruction-side counterpart of sao_stat_one_block. It applies signalled SAO offsets
//  to reconstructed samples of a 4x4 block, one 4-sample row per beat.
//  Edge-offset (EO) category is derived from pre-arranged neighbours along the EO direction.
//  The selected offset is added, then the result is clipped. 2-stage valid/ready pipeline.
//  Sits between the deblocking output buffer and the picture write-back.
// PARAMETERS
//  bit_depth  8  sample width; offsets are signed, range +/-(2^(min(bit_depth,10)-5)-1)
// PORTS
//  clk          in   1           single clock, rising edge
//  rst_n        in   1           asynchronous active-low reset
//  cfg_valid    in   1           offset/type load request
//  cfg_ready    out  1           1 when pipeline empty and row_cnt==0
//  cfg_type     in   2           0 off, 1 EO, 2 BO (BO only with SAO_BAND_OFFSET_EN)
//  cfg_offset   in   4x5 signed  offsets for EO cat1..4 / BO band k..k+3
//  cfg_band_pos in   5           first BO band (ignored in EO)
//  in_valid     in   1           row beat valid
//  in_ready     out  1           row beat accepted when in_valid & in_ready
//  rec_l        in   4xbit_depth neighbour A per column
//  rec_m        in   4xbit_depth current samples
//  rec_r        in   4xbit_depth neighbour B per column
//  out_valid    out  1           result row valid
//  out_ready    in   1           downstream accept
//  out_sample   out  4xbit_depth offset-applied, clipped samples
//  out_last     out  1           marks row 3 of the block
// BEHAVIOUR
//  Reset (async, any time including mid-block):
//   - out_valid=0, out_sample=0, out_last=0; both stages emptied; row_cnt=0.
//   - Config regs: type=off, offsets=0, band_pos=0. in_ready=1, cfg_ready=1 after reset release.
//  Config handshake:
//   - Regs load on cfg_valid&cfg_ready.
//   - A config load and an input beat in the same cycle: only the config loads; in_ready=0 that cycle.
//     Config always wins.
//  Pipeline:
//   - S1 registers the per-column category/band index plus rec_m and the last flag.
//   - S2 registers the clipped sum. Latency accept->out_valid = 2 cycles.
//   - Stage n advances when it is empty or stage n+1 advances. in_ready = !s1_v | s1_adv.
//     Full throughput of 1 row/cycle; no beat is lost or duplicated under any out_ready pattern.
//   - out_sample/out_last are held stable while out_valid & !out_ready.
//  EO:
//   - s = sign(m-l) + sign(m-r), each sign in {-1,0,1}.
//   - Category mapping: s=-2 -> cat1; s=-1 -> cat2; s=+1 -> cat3; s=+2 -> cat4; s=0 -> offset 0.
//  Arithmetic:
//   - sum = {1'b0,m} + sign-extended offset in bit_depth+2 bits.
//   - Clip to [0, 2^bit_depth-1].
//   - type off: out_sample = rec_m, unchanged.
//  row_cnt:
//   - Increments on each accepted beat and wraps 3->0.
//   - out_last is set for the beat accepted with row_cnt==3.
// CONFIGURATION
//  SAO_BAND_OFFSET_EN:
//   - Defined: type 2 is supported.
//     band = m >> (bit_depth-5); idx = (band - band_pos) mod 32.
//     idx<4 uses cfg_offset[idx], otherwise offset 0.
//     Wrap-around is supported, e.g. band_pos=30 covers bands 30,31,0,1.
//   - Undefined: type 2 behaves as off. No band logic is synthesised.
// TESTING
//  1 EO max:
//   - Stimulus: type=1, offsets {3,1,-1,-2}; l=222, m=223, r=221 on all columns.
//   - Response: cat4; out_sample=221 two cycles after accept.
//  2 EO min and flat:
//   - Case a: l=r=225, m=223 gives cat1 and out=226.
//   - Case b: l=m=r=100 gives out=100.
//  3 Clipping:
//   - Case a: m=254, cat1, offset 7 gives out=255.
//   - Case b: m=1, cat4, offset -7 gives out=0.
//  4 Backpressure:
//   - Stimulus: 8 back-to-back beats with out_ready toggling 1010...
//   - Response: 8 outputs in order, none lost, stable while stalled; out_last on beats 4 and 8.
//  5 Config/reset:
//   - cfg_valid with the pipeline busy: cfg_ready=0 until drained; simultaneous in_valid is stalled.
//   - rst_n low after 2 beats: out_valid=0 immediately. Next accepted beat has row_cnt=0.
//  6 BO (SAO_BAND_OFFSET_EN):
//   - Stimulus: band_pos=30, offsets {1,2,3,4}; m=8 (band 1).
//   - Response: out=12. m=16 (band 2) gives out=16.

Source files
------------

// File: rtl/sao_apply_one_block.sv
// SAO apply for a 4x4 block, one 4-sample row per beat, 2-stage valid/ready pipeline.
// Define SAO_BAND_OFFSET_EN to support band offset (type 2); otherwise type 2 passes samples through.
module sao_apply_one_block #(
   parameter int bit_depth = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   input  logic [1:0]                    cfg_type,
   input  logic [3:0][4:0]               cfg_offset,
   input  logic [4:0]                    cfg_band_pos,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [3:0][bit_depth-1:0]     rec_l,
   input  logic [3:0][bit_depth-1:0]     rec_m,
   input  logic [3:0][bit_depth-1:0]     rec_r,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [3:0][bit_depth-1:0]     out_sample,
   output logic                          out_last
);

   logic [1:0]               type_q;
   logic [3:0][4:0]          offset_q;
   logic [1:0]               row_cnt;
   logic                     s1_v;
   logic [3:0][2:0]          s1_code;
   logic [3:0][bit_depth-1:0] s1_m;
   logic                     s1_last;
   logic [3:0][2:0]          cat_code;
   logic                     s2_adv;
   logic                     cfg_load;
   logic                     in_fire;

   // Codes: 0 = no offset, 1..4 select cfg_offset[0..3]
   function automatic logic [2:0] eo_code(input logic [bit_depth-1:0] l,
                                          input logic [bit_depth-1:0] m,
                                          input logic [bit_depth-1:0] r);
      int s;
      s = 0;
      if (m > l) s = s + 1;
      else if (m < l) s = s - 1;
      if (m > r) s = s + 1;
      else if (m < r) s = s - 1;
      case (s)
         -2:      eo_code = 3'd1;
         -1:      eo_code = 3'd2;
         1:       eo_code = 3'd3;
         2:       eo_code = 3'd4;
         default: eo_code = 3'd0;
      endcase
   endfunction

   function automatic logic [bit_depth-1:0] clip_add(input logic [bit_depth-1:0] m,
                                                     input logic [2:0] code,
                                                     input logic [3:0][4:0] offs);
      logic [4:0]           off;
      logic [bit_depth+1:0] sum;
      case (code)
         3'd1:    off = offs[0];
         3'd2:    off = offs[1];
         3'd3:    off = offs[2];
         3'd4:    off = offs[3];
         default: off = 5'd0;
      endcase
      sum = {2'b00, m} + {{(bit_depth-3){off[4]}}, off};
      if (sum[bit_depth+1]) clip_add = '0;
      else if (sum[bit_depth]) clip_add = '1;
      else clip_add = sum[bit_depth-1:0];
   endfunction

`ifdef SAO_BAND_OFFSET_EN
   logic [4:0] band_pos_q;

   // Band index is taken modulo 32, so band_pos near 31 wraps onto bands 0,1,...
   function automatic logic [2:0] bo_code(input logic [bit_depth-1:0] m,
                                          input logic [4:0] pos);
      logic [4:0] idx;
      idx = m[bit_depth-1 -: 5] - pos;
      bo_code = (idx < 5'd4) ? ({1'b0, idx[1:0]} + 3'd1) : 3'd0;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         band_pos_q <= 5'd0;
      end else if (cfg_load) begin
         band_pos_q <= cfg_band_pos;
      end
   end
`else
   logic unused_band_pos;
   assign unused_band_pos = ^cfg_band_pos;
`endif

   // Config only loads into an idle pipeline at a block boundary and beats yield to it
   assign s2_adv    = !out_valid || out_ready;
   assign cfg_ready = !s1_v && !out_valid && (row_cnt == 2'd0);
   assign cfg_load  = cfg_valid && cfg_ready;
   assign in_ready  = (!s1_v || s2_adv) && !cfg_load;
   assign in_fire   = in_valid && in_ready;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cat_code[i] = 3'd0;
         if (type_q == 2'd1) begin
            cat_code[i] = eo_code(rec_l[i], rec_m[i], rec_r[i]);
         end
`ifdef SAO_BAND_OFFSET_EN
         else if (type_q == 2'd2) begin
            cat_code[i] = bo_code(rec_m[i], band_pos_q);
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         type_q   <= 2'd0;
         offset_q <= '0;
      end else if (cfg_load) begin
         type_q   <= cfg_type;
         offset_q <= cfg_offset;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_cnt <= 2'd0;
      end else if (in_fire) begin
         row_cnt <= row_cnt + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v    <= 1'b0;
         s1_code <= '0;
         s1_m    <= '0;
         s1_last <= 1'b0;
      end else if (!s1_v || s2_adv) begin
         s1_v <= in_fire;
         if (in_fire) begin
            s1_code <= cat_code;
            s1_m    <= rec_m;
            s1_last <= (row_cnt == 2'd3);
         end
      end
   end

   // Output registers only change when downstream can take them, so stalled data stays put
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_sample <= '0;
         out_last   <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_v;
         if (s1_v) begin
            for (int i = 0; i < 4; i++) begin
               out_sample[i] <= clip_add(s1_m[i], s1_code[i], offset_q);
            end
            out_last <= s1_last;
         end
      end
   end

endmodule

// File: tb/tb_sao_apply_one_block.sv
// Directed scoreboard bench for sao_apply_one_block (bit_depth 8).
// Band-offset expectations follow SAO_BAND_OFFSET_EN when it is defined for the build.
module tb_sao_apply_one_block;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [1:0]       cfg_type = 2'd0;
   logic [3:0][4:0]  cfg_offset = '0;
   logic [4:0]       cfg_band_pos = 5'd0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [3:0][7:0]  rec_l = '0;
   logic [3:0][7:0]  rec_m = '0;
   logic [3:0][7:0]  rec_r = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [3:0][7:0]  out_sample;
   logic             out_last;

   int               n_total = 0;
   int               n_bad = 0;
   logic [32:0]      exp_q[$];
   int               tb_row = 0;
   int               ready_mode = 0;
   logic             prev_stall = 1'b0;
   logic [31:0]      prev_sample = '0;
   logic             prev_last = 1'b0;

   sao_apply_one_block #(.bit_depth(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_type(cfg_type),
      .cfg_offset(cfg_offset), .cfg_band_pos(cfg_band_pos),
      .in_valid(in_valid), .in_ready(in_ready),
      .rec_l(rec_l), .rec_m(rec_m), .rec_r(rec_r),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sample(out_sample), .out_last(out_last)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] all4(input logic [7:0] v);
      all4 = {4{v}};
   endfunction

   function automatic logic [19:0] offs(input int a, input int b, input int c, input int d);
      offs = {5'(d), 5'(c), 5'(b), 5'(a)};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic report_timeout(input string name);
      n_total++;
      n_bad++;
      $display("[TB] FAIL %s: got no handshake want one within 100 cycles", name);
   endtask

   // Downstream ready pattern, changed just after each rising edge
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         default: out_ready = 1'b0;
      endcase
   end

   // Monitor: pops the scoreboard on each output handshake and checks stalled data holds
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_hold", {out_last, out_sample}, {prev_last, prev_sample});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_total++;
               n_bad++;
               $display("[TB] FAIL unexpected_out: got row 0x%0h want no output", {out_last, out_sample});
            end else begin
               checkOutput("out_row", {out_last, out_sample}, exp_q.pop_front());
            end
         end
         prev_stall  = out_valid && !out_ready;
         prev_sample = out_sample;
         prev_last   = out_last;
      end
   end

   // Called at a falling edge; returns at the falling edge after the beat is accepted
   task automatic applyStimulus(input logic [31:0] l, input logic [31:0] m,
                                input logic [31:0] r, input logic [31:0] exp);
      logic acc;
      bit   done;
      done = 0;
      rec_l = l;
      rec_m = m;
      rec_r = r;
      in_valid = 1'b1;
      for (int n = 0; n < 100; n++) begin
         #1;
         acc = in_ready;
         @(posedge clk);
         if (acc) begin
            done = 1;
            break;
         end
         @(negedge clk);
      end
      if (done) begin
         exp_q.push_back({(tb_row == 3), exp});
         tb_row = (tb_row + 1) % 4;
      end else begin
         report_timeout("beat_accept");
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic load_config(input logic [1:0] t, input logic [19:0] o, input logic [4:0] bp);
      bit done;
      done = 0;
      cfg_type = t;
      cfg_offset = o;
      cfg_band_pos = bp;
      cfg_valid = 1'b1;
      for (int n = 0; n < 100; n++) begin
         #1;
         if (cfg_ready) begin
            @(posedge clk);
            done = 1;
            break;
         end
         @(negedge clk);
      end
      if (!done) report_timeout("cfg_accept");
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   initial begin
      bit seen;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_sample", out_sample, 0);
      checkOutput("rst_out_last", out_last, 0);
      rst_n = 1'b1;
      #1;
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_cfg_ready", cfg_ready, 1);
      @(negedge clk);

      $display("[TB] EO categories");
      load_config(2'd1, offs(3, 1, -1, -2), 5'd0);
      applyStimulus(all4(222), all4(223), all4(221), all4(221));
      applyStimulus(all4(225), all4(223), all4(225), all4(226));
      applyStimulus(all4(100), all4(100), all4(100), all4(100));
      applyStimulus({8'd50, 8'd40, 8'd60, 8'd50}, all4(50),
                    {8'd40, 8'd50, 8'd50, 8'd60}, {8'd49, 8'd49, 8'd51, 8'd51});

      $display("[TB] clipping");
      load_config(2'd1, offs(7, 0, 0, -7), 5'd0);
      applyStimulus(all4(255), all4(254), all4(255), all4(255));
      applyStimulus(all4(0), all4(1), all4(0), all4(0));
      applyStimulus(all4(255), all4(248), all4(255), all4(255));
      applyStimulus(all4(0), all4(7), all4(0), all4(0));

      $display("[TB] type off");
      load_config(2'd0, offs(7, 7, 7, 7), 5'd0);
      applyStimulus(all4(5), all4(0), all4(5), all4(0));
      applyStimulus(all4(0), all4(255), all4(0), all4(255));
      applyStimulus(all4(25), {8'd10, 8'd20, 8'd30, 8'd40}, all4(25), {8'd10, 8'd20, 8'd30, 8'd40});
      applyStimulus(all4(127), all4(128), all4(129), all4(128));

      $display("[TB] type 2");
      load_config(2'd2, offs(1, 2, 3, 4), 5'd30);
`ifdef SAO_BAND_OFFSET_EN
      applyStimulus(all4(255), all4(8), all4(255), all4(12));
      applyStimulus(all4(255), all4(16), all4(255), all4(16));
      applyStimulus(all4(255), {8'd0, 8'd255, 8'd248, 8'd240}, all4(255), {8'd3, 8'd255, 8'd250, 8'd241});
      applyStimulus(all4(255), all4(100), all4(255), all4(100));
`else
      applyStimulus(all4(255), all4(8), all4(255), all4(8));
      applyStimulus(all4(255), all4(16), all4(255), all4(16));
      applyStimulus(all4(255), {8'd0, 8'd255, 8'd248, 8'd240}, all4(255), {8'd0, 8'd255, 8'd248, 8'd240});
      applyStimulus(all4(255), all4(100), all4(255), all4(100));
`endif

      $display("[TB] backpressure");
      load_config(2'd1, offs(3, 1, -1, -2), 5'd0);
      ready_mode = 1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(all4(8'(25 + 10 * i)), all4(8'(20 + 10 * i)),
                       all4(8'(25 + 10 * i)), all4(8'(23 + 10 * i)));
      end

      $display("[TB] config while busy");
      cfg_type = 2'd1;
      cfg_offset = offs(5, 0, 0, 0);
      cfg_band_pos = 5'd0;
      cfg_valid = 1'b1;
      #1;
      checkOutput("cfg_ready_busy", cfg_ready, 0);
      seen = 0;
      for (int n = 0; n < 100; n++) begin
         if (cfg_ready) begin
            seen = 1;
            break;
         end
         @(negedge clk);
         #1;
      end
      if (!seen) report_timeout("cfg_drain");
      rec_l = all4(55);
      rec_m = all4(50);
      rec_r = all4(55);
      in_valid = 1'b1;
      #1;
      checkOutput("in_ready_cfg_wins", in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0;
      ready_mode = 2;
      applyStimulus(all4(55), all4(50), all4(55), all4(55));
      applyStimulus(all4(65), all4(60), all4(65), all4(65));
      checkOutput("busy_before_reset", out_valid, 1);

      $display("[TB] mid-block reset");
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_out_valid", out_valid, 0);
      checkOutput("midrst_out_sample", out_sample, 0);
      checkOutput("midrst_out_last", out_last, 0);
      exp_q.delete();
      tb_row = 0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      ready_mode = 0;
      #1;
      checkOutput("midrst_in_ready", in_ready, 1);
      checkOutput("midrst_cfg_ready", cfg_ready, 1);
      @(negedge clk);
      applyStimulus(all4(90), all4(77), all4(90), all4(77));
      applyStimulus(all4(160), all4(150), all4(160), all4(150));
      applyStimulus(all4(9), all4(3), all4(9), all4(3));
      applyStimulus(all4(210), all4(200), all4(210), all4(200));

      for (int n = 0; n < 50; n++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      checkOutput("drain_empty", exp_q.size(), 0);
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
